// File: rtl/aes_inv_ctrl.sv
// ============================================================================
// aes_inv_ctrl : AES inverse-cipher sequencing FSM (load, key expand, rounds).
// Optional macro AES_INV_BACK2BACK_EN: accept a new start in DONE.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_inv_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aes_start,
  output logic       aes_ready,
  output logic       aes_valid,
  output logic [3:0] rnd_idx,
  output logic       ciphertext_en,
  output logic       key_en,
  output logic       state_en,
  output logic       rndkey_en,
  output logic       keyexp_fwd,
  output logic       ark_only_ctrl,
  output logic       skip_mix_ctrl,
  output logic       plaintext_en
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KEYEXP = 3'd2,
    S_ARK    = 3'd3,
    S_ROUND  = 3'd4,
    S_LAST   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [3:0] C_NR = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // The key schedule runs forward to rk[NR], then the rounds walk it back down.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    case (state_q)
      S_IDLE: begin
        rnd_d = 4'd0;
        if (aes_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_KEYEXP;
        rnd_d   = 4'd1;
      end
      S_KEYEXP: begin
        if (rnd_q == C_NR) begin
          state_d = S_ARK;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_ARK: begin
        state_d = S_ROUND;
        rnd_d   = C_NR - 4'd1;
      end
      S_ROUND: begin
        if (rnd_q == 4'd1) begin
          state_d = S_LAST;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      S_LAST: begin
        state_d = S_DONE;
        rnd_d   = 4'd0;
      end
      S_DONE: begin
        rnd_d = 4'd0;
`ifdef AES_INV_BACK2BACK_EN
        state_d = aes_start ? S_LOAD : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    aes_ready     = 1'b0;
    aes_valid     = 1'b0;
    ciphertext_en = 1'b0;
    key_en        = 1'b0;
    state_en      = 1'b0;
    rndkey_en     = 1'b0;
    keyexp_fwd    = 1'b0;
    ark_only_ctrl = 1'b0;
    skip_mix_ctrl = 1'b0;
    plaintext_en  = 1'b0;
    rnd_idx       = rnd_q;
    case (state_q)
      S_IDLE: aes_ready = 1'b1;
      S_LOAD: begin
        ciphertext_en = 1'b1;
        key_en        = 1'b1;
      end
      S_KEYEXP: begin
        rndkey_en  = 1'b1;
        keyexp_fwd = 1'b1;
      end
      S_ARK: begin
        state_en      = 1'b1;
        ark_only_ctrl = 1'b1;
        rndkey_en     = 1'b1;
      end
      S_ROUND: begin
        state_en  = 1'b1;
        rndkey_en = 1'b1;
      end
      S_LAST: begin
        state_en      = 1'b1;
        skip_mix_ctrl = 1'b1;
        plaintext_en  = 1'b1;
      end
      S_DONE: begin
        aes_valid = 1'b1;
`ifdef AES_INV_BACK2BACK_EN
        aes_ready = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_ctrl.sv
// ============================================================================
// tb_aes_inv_ctrl : directed self-checking bench for aes_inv_ctrl (NR=10).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_inv_ctrl;

  localparam int NR = 10;
`ifdef AES_INV_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       aes_start;
  logic       aes_ready, aes_valid;
  logic [3:0] rnd_idx;
  logic       ciphertext_en, key_en, state_en, rndkey_en;
  logic       keyexp_fwd, ark_only_ctrl, skip_mix_ctrl, plaintext_en;

  int checks   = 0;
  int failures = 0;

  aes_inv_ctrl #(.NR(NR)) dut (
    .clk           (clk),
    .rst           (rst),
    .aes_start     (aes_start),
    .aes_ready     (aes_ready),
    .aes_valid     (aes_valid),
    .rnd_idx       (rnd_idx),
    .ciphertext_en (ciphertext_en),
    .key_en        (key_en),
    .state_en      (state_en),
    .rndkey_en     (rndkey_en),
    .keyexp_fwd    (keyexp_fwd),
    .ark_only_ctrl (ark_only_ctrl),
    .skip_mix_ctrl (skip_mix_ctrl),
    .plaintext_en  (plaintext_en)
  );

  always #5 clk = ~clk;

  // {ready, valid, rnd_idx[3:0], ct, key, state, rndkey, fwd, ark, skip, pt}
  wire [13:0] obs = {aes_ready, aes_valid, rnd_idx, ciphertext_en, key_en, state_en,
                     rndkey_en, keyexp_fwd, ark_only_ctrl, skip_mix_ctrl, plaintext_en};
  localparam logic [13:0] IDLE_VEC = 14'b10_0000_0000_0000;

  // Expected outputs j cycles after the start-sampling edge (j=0 is LOAD).
  function automatic logic [13:0] exp_at(input int j);
    logic       r, v, ct, ke, st, rk, fw, ark, sk, pt;
    logic [3:0] idx;
    {r, v, ct, ke, st, rk, fw, ark, sk, pt} = '0;
    idx = 4'd0;
    if (j == 0) begin
      ct = 1'b1; ke = 1'b1;
    end else if (j <= NR) begin
      idx = 4'(j); rk = 1'b1; fw = 1'b1;
    end else if (j == NR + 1) begin
      idx = 4'(NR); st = 1'b1; ark = 1'b1; rk = 1'b1;
    end else if (j <= 2 * NR) begin
      idx = 4'(2 * NR + 1 - j); st = 1'b1; rk = 1'b1;
    end else if (j == 2 * NR + 1) begin
      st = 1'b1; sk = 1'b1; pt = 1'b1;
    end else begin
      v = 1'b1; r = B2B;
    end
    return {r, v, idx, ct, ke, st, rk, fw, ark, sk, pt};
  endfunction

  task automatic start_pulse();
    aes_start = 1'b1;
    @(posedge clk); #1;
    aes_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; aes_start = 1'b0;
    #2;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_async obs=%b exp=%b", obs, IDLE_VEC);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_held obs=%b exp=%b", obs, IDLE_VEC);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_release obs=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_single();
    int sum;
    start_pulse();
    for (int j = 0; j <= 2 * NR + 2; j++) begin
      checks++;
      if (obs !== exp_at(j)) begin
        failures++;
        $display("FAIL single_seq j=%0d obs=%b exp=%b", j, obs, exp_at(j));
      end
      sum = int'(ciphertext_en) + int'(state_en) + int'(plaintext_en & ~state_en);
      checks++;
      if (sum > 1 || (key_en && rndkey_en)) begin
        failures++;
        $display("FAIL enable_excl j=%0d obs=%b exp=exclusive", j, obs);
      end
      checks++;
      if (keyexp_fwd !== (j >= 1 && j <= NR) || skip_mix_ctrl !== (j == 2 * NR + 1)) begin
        failures++;
        $display("FAIL fwd_skip j=%0d fwd=%b skip=%b", j, keyexp_fwd, skip_mix_ctrl);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL single_idle obs=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_start_held();
    aes_start = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j <= 2 * NR + 2; j++) begin
      checks++;
      if (obs !== exp_at(j)) begin
        failures++;
        $display("FAIL held_seq j=%0d obs=%b exp=%b", j, obs, exp_at(j));
      end
      @(posedge clk); #1;
    end
    if (!B2B) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        failures++;
        $display("FAIL held_idle obs=%b exp=%b", obs, IDLE_VEC);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== exp_at(0)) begin
      failures++;
      $display("FAIL held_reload obs=%b exp=%b", obs, exp_at(0));
    end
    aes_start = 1'b0;
    repeat (2 * NR + 3) @(posedge clk);
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL held_drain obs=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_valid, ready_ok;
    start_pulse();
    repeat (2 * NR - 4) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_at(2 * NR - 4) || rnd_idx !== 4'd5) begin
      failures++;
      $display("FAIL mid_round5 obs=%b exp=%b", obs, exp_at(2 * NR - 4));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL mid_reset obs=%b exp=%b", obs, IDLE_VEC);
    end
    @(negedge clk); rst = 1'b0;
    seen_valid = 1'b0; ready_ok = 1'b1;
    for (int c = 0; c < 2 * NR + 6; c++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | aes_valid;
      ready_ok   = ready_ok & aes_ready;
    end
    checks++;
    if (seen_valid !== 1'b0 || ready_ok !== 1'b1) begin
      failures++;
      $display("FAIL mid_no_valid valid_seen=%b ready_ok=%b exp=0/1", seen_valid, ready_ok);
    end
    start_pulse();
    repeat (2 * NR + 2) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_at(2 * NR + 2)) begin
      failures++;
      $display("FAIL mid_restart obs=%b exp=%b", obs, exp_at(2 * NR + 2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    start_pulse();
    repeat (2 * NR + 2) @(posedge clk);
    #1;
    checks++;
    if (aes_valid !== 1'b1 || aes_ready !== B2B) begin
      failures++;
      $display("FAIL b2b_done valid=%b ready=%b exp=1/%b", aes_valid, aes_ready, B2B);
    end
    aes_start = 1'b1;
    @(posedge clk); #1;
    aes_start = 1'b0;
    if (B2B) begin
      checks++;
      if (obs !== exp_at(0)) begin
        failures++;
        $display("FAIL b2b_load obs=%b exp=%b", obs, exp_at(0));
      end
      // Second valid must land 23 cycles after the first.
      repeat (2 * NR + 2) @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_at(2 * NR + 2)) begin
        failures++;
        $display("FAIL b2b_second_valid obs=%b exp=%b", obs, exp_at(2 * NR + 2));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL b2b_idle obs=%b exp=%b", obs, IDLE_VEC);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL b2b_no_load obs=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
